// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter, valid/ready byte input, optional even parity via UART_TX_PARITY_EN
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 signal,
    output logic                 busy
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         BIT_LAST = 3'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_clk_cnt;
    logic [2:0]             r_bit_idx;
    logic                   r_signal;
    logic                   r_busy;
    logic                   r_ready_en;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    logic w_bit_done;
    logic w_accept;

    assign w_bit_done = (r_clk_cnt == CNT_LAST);
    // r_ready_en holds data_ready low through reset and for the first clock after release
    assign data_ready = r_ready_en &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign w_accept   = data_valid && data_ready;
    assign signal     = r_signal;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_signal   <= 1'b1;
            r_busy     <= 1'b0;
            r_ready_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                // Accept is only possible in IDLE or the last STOP cycle, so no gap between frames
                r_state   <= S_START;
                r_shift   <= data_in;
                r_clk_cnt <= '0;
                r_bit_idx <= '0;
                r_signal  <= 1'b0;
                r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^data_in;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_signal  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_clk_cnt <= '0;
                    end
                    S_START: begin
                        if (w_bit_done) begin
                            r_clk_cnt <= '0;
                            r_state   <= S_DATA;
                            r_signal  <= r_shift[0];
                        end else begin
                            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_bit_done) begin
                            r_clk_cnt <= '0;
                            if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                                r_state  <= S_PARITY;
                                r_signal <= r_parity;
`else
                                r_state  <= S_STOP;
                                r_signal <= 1'b1;
`endif
                            end else begin
                                r_shift   <= r_shift >> 1;
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_signal  <= r_shift[1];
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (w_bit_done) begin
                            r_clk_cnt <= '0;
                            r_state   <= S_STOP;
                            r_signal  <= 1'b1;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_bit_done) begin
                            r_clk_cnt <= '0;
                            r_state   <= S_IDLE;
                            r_signal  <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_clk_cnt <= '0;
                        r_signal  <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
